// File: rtl/glb_netwk_monitor_if.sv
// Bus bundle for the global-network edge monitor: net inputs, run control and readback.
interface glb_netwk_monitor_if #(
    parameter int NETS  = 8,
    parameter int CNT_W = 16
);
    logic [NETS-1:0]  glb_in;
    logic             start;
    logic             busy;
    logic             done;
    logic [2:0]       rd_sel;
    logic [CNT_W-1:0] rd_count;
    logic [NETS-1:0]  ovf;

    modport master (
        output glb_in, start, rd_sel,
        input  busy, done, rd_count, ovf
    );

    modport slave (
        input  glb_in, start, rd_sel,
        output busy, done, rd_count, ovf
    );
endinterface

// File: rtl/glb_netwk_monitor.sv
// Counts rising edges on each global net over a fixed window of clk cycles and
// returns the per-net counts one net at a time through a registered readback port.
module glb_netwk_monitor #(
    parameter int NETS   = 8,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000
) (
    input  logic                clk,
    input  logic                resetn,
    glb_netwk_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [23:0]      TIMER_LD  = 24'(WINDOW - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [NETS-1:0]  sync1_r;
    logic [NETS-1:0]  sync2_r;
    logic [NETS-1:0]  hist_r;
    logic [NETS-1:0]  edge_s;
    logic [CNT_W-1:0] cnt_r [NETS];
    logic [NETS-1:0]  ovf_r;
    logic [23:0]      timer_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] rd_count_r;
    logic [CNT_W-1:0] rd_next_s;

    assign edge_s = sync2_r & ~hist_r;

    // Two-flop synchroniser plus one history flop per net for rising-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_r <= '0;
            sync2_r <= '0;
            hist_r  <= '0;
        end else begin
            sync1_r <= bus.glb_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is never queued.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_state_s = ST_ARM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                next_state_s = ST_COUNT;
            end
            ST_COUNT: begin
                if (timer_r == 24'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_COUNT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_ARM) || (next_state_s == ST_COUNT);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    // Window timer: loaded in ARM, counts down through COUNT; zero marks the last counted cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 24'd0;
        end else if (state_r == ST_ARM) begin
            timer_r <= TIMER_LD;
        end else if ((state_r == ST_COUNT) && (timer_r != 24'd0)) begin
            timer_r <= timer_r - 24'd1;
        end
    end

    // Per-net edge counters with saturation; overflow is sticky until the next ARM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NETS; i++) begin
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else if (state_r == ST_ARM) begin
            for (int i = 0; i < NETS; i++) begin
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else if (state_r == ST_COUNT) begin
            for (int i = 0; i < NETS; i++) begin
                if (edge_s[i]) begin
                    if (cnt_r[i] == CNT_MAX) begin
                        ovf_r[i] <= 1'b1;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

    // Readback select; indices beyond the implemented nets fall through to zero.
    always_comb begin
        rd_next_s = '0;
        for (int i = 0; i < NETS; i++) begin
            rd_next_s = (bus.rd_sel == 3'(i)) ? cnt_r[i] : rd_next_s;
        end
    end

    // Registered readback, updated every cycle in every state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_count_r <= '0;
        end else begin
            rd_count_r <= rd_next_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rd_count = rd_count_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_glb_netwk_monitor.sv
// Directed bench for glb_netwk_monitor: one full-size instance and one narrow
// instance (4 nets, 4-bit counters) driven from a single linear stimulus sequence.
module tb_glb_netwk_monitor;
    localparam int WA = 1000;
    localparam int WB = 100;

    logic clk;
    logic resetn_a;
    logic resetn_b;

    glb_netwk_monitor_if #(.NETS(8), .CNT_W(16)) ia ();
    glb_netwk_monitor_if #(.NETS(4), .CNT_W(4))  ib ();

    glb_netwk_monitor #(.NETS(8), .CNT_W(16), .WINDOW(WA)) dut_a (
        .clk    (clk),
        .resetn (resetn_a),
        .bus    (ia.slave)
    );

    glb_netwk_monitor #(.NETS(4), .CNT_W(4), .WINDOW(WB)) dut_b (
        .clk    (clk),
        .resetn (resetn_b),
        .bus    (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_a   = 0;
    int busy_a   = 0;
    int done_cyc_a = 0;
    int done_b   = 0;
    int half_a [8];
    int half_b [4];

    // Advance one clock, tally status outputs, then drive the net waveforms.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ia.done === 1'b1) begin
            done_a++;
            done_cyc_a = cyc;
        end
        if (ia.busy === 1'b1) busy_a++;
        if (ib.done === 1'b1) done_b++;
        for (int k = 0; k < 8; k++)
            ia.glb_in[k] = (half_a[k] == 0) ? 1'b0 : (((cyc / half_a[k]) % 2) == 1);
        for (int k = 0; k < 4; k++)
            ib.glb_in[k] = (half_b[k] == 0) ? 1'b0 : (((cyc / half_b[k]) % 2) == 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_done_a(input int budget);
        int d0 = done_a;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_a != d0) break;
        end
        chk("a_done_seen", 32'(done_a - d0), 32'd1);
    endtask

    task automatic wait_done_b(input int budget);
        int d0 = done_b;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_b != d0) break;
        end
        chk("b_done_seen", 32'(done_b - d0), 32'd1);
    endtask

    task automatic run_a();
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        wait_done_a(WA + 20);
    endtask

    int c0;
    int exp_cnt;
    int sel_seq [8] = '{3, 0, 3, 1, 3, 7, 2, 3};
    int exp_seq [8] = '{15, 0, 15, 0, 15, 0, 0, 15};

    initial begin
        for (int k = 0; k < 8; k++) half_a[k] = 0;
        for (int k = 0; k < 4; k++) half_b[k] = 0;
        resetn_a  = 1'b0;
        resetn_b  = 1'b0;
        ia.glb_in = 8'd0;
        ia.start  = 1'b0;
        ia.rd_sel = 3'd0;
        ib.glb_in = 4'd0;
        ib.start  = 1'b0;
        ib.rd_sel = 3'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  32'(ia.busy), 32'd0);
        chk("rst_done",  32'(ia.done), 32'd0);
        chk("rst_count", 32'(ia.rd_count), 32'd0);
        chk("rst_ovf",   32'(ia.ovf), 32'd0);
        chk("rst_ovf_b", 32'(ib.ovf), 32'd0);
        resetn_a = 1'b1;
        resetn_b = 1'b1;
        repeat (3) tick();

        // Single toggling net, plus start retries during COUNT and at DONE
        half_a[0] = 2;
        repeat (5) tick();
        busy_a = 0;
        done_a = 0;
        c0 = cyc;
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        repeat (11) tick();
        chk("busy_in_count", 32'(ia.busy), 32'd1);
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        wait_done_a(WA + 20);
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        repeat (20) tick();
        chk("done_latency", 32'(done_cyc_a - c0), 32'(WA + 2));
        chk("done_pulses",  32'(done_a), 32'd1);
        chk("busy_cycles",  32'(busy_a), 32'(WA + 1));
        chk("idle_after",   32'(ia.busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            ia.rd_sel = 3'(k);
            tick();
            if (k == 0) chk_rng("t1_net0", int'(ia.rd_count), 249, 251);
            else        chk("t1_netk", 32'(ia.rd_count), 32'd0);
        end
        chk("t1_ovf", 32'(ia.ovf), 32'd0);

        // Distinct rates per net
        for (int k = 0; k < 8; k++) half_a[k] = 2 * (k + 1);
        repeat (5) tick();
        run_a();
        for (int k = 0; k < 8; k++) begin
            ia.rd_sel = 3'(k);
            tick();
            exp_cnt = WA / (4 * (k + 1));
            chk_rng("t2_rate", int'(ia.rd_count), exp_cnt - 1, exp_cnt + 1);
        end

        // Reset in the middle of COUNT
        for (int k = 1; k < 8; k++) half_a[k] = 0;
        ia.rd_sel = 3'd0;
        repeat (5) tick();
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        repeat (500) tick();
        chk("t5_live_nonzero", 32'(ia.rd_count > 16'd0), 32'd1);
        resetn_a = 1'b0;
        #1;
        chk("t5_busy",  32'(ia.busy), 32'd0);
        chk("t5_done",  32'(ia.done), 32'd0);
        chk("t5_count", 32'(ia.rd_count), 32'd0);
        chk("t5_ovf",   32'(ia.ovf), 32'd0);
        repeat (3) tick();
        resetn_a = 1'b1;
        done_a = 0;
        repeat (WA + 50) tick();
        chk("t5_no_done", 32'(done_a), 32'd0);
        run_a();
        tick();
        chk_rng("t5_recount", int'(ia.rd_count), 249, 251);

        // Saturation on the narrow instance, then re-arm
        half_b[3] = 2;
        ib.rd_sel = 3'd3;
        repeat (5) tick();
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        wait_done_b(WB + 20);
        tick();
        chk("t3_sat",  32'(ib.rd_count), 32'd15);
        chk("t3_ovf",  32'(ib.ovf), 32'd8);
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        tick();
        chk("t3_ovf_cleared", 32'(ib.ovf), 32'd0);
        wait_done_b(WB + 20);
        tick();
        chk("t3_sat2", 32'(ib.rd_count), 32'd15);
        chk("t3_ovf2", 32'(ib.ovf), 32'd8);

        // Readback latency with rd_sel changing every cycle, including an index past NETS
        for (int i = 0; i < 8; i++) begin
            ib.rd_sel = 3'(sel_seq[i]);
            tick();
            chk("t6_readback", 32'(ib.rd_count), 32'(exp_seq[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
